ifetch_queue: RTL and testbench

Parametrised line-granular instruction fetch unit with a decoupling fetch queue between the I-cache and decode. Each cycle it reads one cache line at the fetch PC and pushes a fetch packet (line words, valid mask, line base PC, stream tag) into a DEPTH-entry FIFO. Decode pops packets with a valid/ready handshake. A redirect (branch/exception) flushes the queue, reloads the PC and toggles the stream tag.

---
 rtl/ifetch_queue.sv | 108 ++++++++++
 tb/tb_ifetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: line-granular instruction fetch unit feeding decode through a flushable FIFO
module ifetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int DEPTH = 4,
    localparam int DATA_WIDTH = 32 * LINE_WORDS
) (
    input  logic                           clock,
    input  logic                           reset_n,
    output logic [ADDR_WIDTH-1:0]          cache_addr,
    output logic                           cache_rd,
    input  logic [DATA_WIDTH-1:0]          cache_data,
    input  logic                           cache_waitrequest,
    input  logic                           load_pc,
    input  logic [ADDR_WIDTH-1:0]          new_pc,
    output logic                           redirect_stall,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_words,
    output logic [LINE_WORDS-1:0]          out_mask,
    output logic [ADDR_WIDTH-1:0]          out_pc,
    output logic                           out_stream,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int OB = OW + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  stream;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] q_words [DEPTH];
    logic [LINE_WORDS-1:0] q_mask [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc [DEPTH];
    logic                  q_stream [DEPTH];
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  accept_redirect;
    logic [ADDR_WIDTH-1:0] base;
    logic [LINE_WORDS-1:0] mask_in;
    // full blocks push even when the head is popping this cycle; no bypass path
    assign full            = count == CW'(DEPTH);
    assign push            = ~full & ~cache_waitrequest & ~load_pc;
    assign pop             = out_valid & out_ready;
    assign accept_redirect = load_pc & ~cache_waitrequest;
    assign redirect_stall  = load_pc & cache_waitrequest;
    assign cache_addr      = pc;
    assign cache_rd        = ~full;
    assign base            = {pc[ADDR_WIDTH-1:OB], {OB{1'b0}}};
    assign out_valid       = count != '0;
    assign occupancy       = count;
    assign out_words       = q_words[rd_ptr];
    assign out_mask        = q_mask[rd_ptr];
    assign out_pc          = q_pc[rd_ptr];
    assign out_stream      = q_stream[rd_ptr];
    // words before the fetch PC within its line are not part of the stream
    always_comb begin
        mask_in = '0;
        for (int i = 0; i < LINE_WORDS; i++) mask_in[i] = OW'(i) >= pc[OB-1:2];
    end
    // fetch PC and stream tag: redirect reloads and toggles, push steps to the next line
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= '0;
            stream <= 1'b0;
        end else if (accept_redirect) begin
            pc     <= new_pc;
            stream <= ~stream;
        end else if (push) begin
            pc     <= base + ADDR_WIDTH'(4 * LINE_WORDS);
        end
    end
    // queue pointers and occupancy; a redirect flush dominates any same-cycle pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (accept_redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end
    // packet storage; cleared on reset so the head outputs read zero until the first push
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_words[i]  <= '0;
                q_mask[i]   <= '0;
                q_pc[i]     <= '0;
                q_stream[i] <= 1'b0;
            end
        end else if (push) begin
            q_words[wr_ptr]  <= cache_data;
            q_mask[wr_ptr]   <= mask_in;
            q_pc[wr_ptr]     <= base;
            q_stream[wr_ptr] <= stream;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed checks of ifetch_queue with a line-address-as-data cache model
module tb_ifetch_queue;
    logic         clock = 1'b0;
    logic         reset_n;
    logic [31:0]  cache_addr;
    logic         cache_rd;
    logic [127:0] cache_data;
    logic         cache_waitrequest;
    logic         load_pc;
    logic [31:0]  new_pc;
    logic         redirect_stall;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_words;
    logic [3:0]   out_mask;
    logic [31:0]  out_pc;
    logic         out_stream;
    logic [2:0]   occupancy;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_head;

    ifetch_queue #(.ADDR_WIDTH(32), .LINE_WORDS(4), .DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .cache_addr(cache_addr), .cache_rd(cache_rd),
        .cache_data(cache_data), .cache_waitrequest(cache_waitrequest), .load_pc(load_pc),
        .new_pc(new_pc), .redirect_stall(redirect_stall), .out_valid(out_valid),
        .out_ready(out_ready), .out_words(out_words), .out_mask(out_mask), .out_pc(out_pc),
        .out_stream(out_stream), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'hF;
        return {b, b + 32'd4, b + 32'd8, b + 32'd12};
    endfunction

    assign cache_data = line_of(cache_addr);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        load_pc = 1'b0;
        new_pc = '0;
        cache_waitrequest = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_addr", cache_addr, 0);
        check("rst_rd", cache_rd, 1);
        check("rst_stall", redirect_stall, 0);
        check("rst_words", out_words, 0);
        check("rst_mask", out_mask, 0);
        check("rst_pc", out_pc, 0);
        check("rst_stream", out_stream, 0);
        #1 reset_n = 1'b1;
        // fill with decode stalled
        tick();
        check("fill1_valid", out_valid, 1);
        check("fill1_occ", occupancy, 1);
        check("fill1_pc", out_pc, 32'h0);
        check("fill1_mask", out_mask, 4'b1111);
        check("fill1_words", out_words, line_of(32'h0));
        check("fill1_addr", cache_addr, 32'h10);
        tick();
        tick();
        tick();
        check("fill4_occ", occupancy, 4);
        check("fill4_rd", cache_rd, 0);
        check("fill4_addr", cache_addr, 32'h40);
        check("fill4_head", out_pc, 32'h0);
        tick();
        check("full_hold_occ", occupancy, 4);
        check("full_hold_addr", cache_addr, 32'h40);
        // redirect into mid-line target with decode ready
        load_pc = 1'b1;
        new_pc = 32'h1008;
        out_ready = 1'b1;
        #1 check("redir_nostall", redirect_stall, 0);
        tick();
        load_pc = 1'b0;
        out_ready = 1'b0;
        check("redir_valid", out_valid, 0);
        check("redir_occ", occupancy, 0);
        check("redir_stream", out_stream, 0);
        check("redir_addr", cache_addr, 32'h1008);
        tick();
        check("mid_valid", out_valid, 1);
        check("mid_pc", out_pc, 32'h1000);
        check("mid_mask", out_mask, 4'b1100);
        check("mid_stream", out_stream, 1);
        check("mid_words", out_words, line_of(32'h1000));
        out_ready = 1'b1;
        tick();
        check("next_pc", out_pc, 32'h1010);
        check("next_mask", out_mask, 4'b1111);
        check("next_occ", occupancy, 1);
        check("next_addr", cache_addr, 32'h1020);
        // redirect refused while the cache stalls
        out_ready = 1'b0;
        cache_waitrequest = 1'b1;
        load_pc = 1'b1;
        new_pc = 32'h2000;
        #1 check("stall_c0", redirect_stall, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_flag", redirect_stall, 1);
            check("stall_occ", occupancy, 1);
            check("stall_addr", cache_addr, 32'h1020);
            check("stall_head", out_pc, 32'h1010);
        end
        tick();
        check("stall_last_stream", out_stream, 1);
        cache_waitrequest = 1'b0;
        #1 check("stall_release", redirect_stall, 0);
        tick();
        load_pc = 1'b0;
        check("acc_valid", out_valid, 0);
        check("acc_occ", occupancy, 0);
        check("acc_addr", cache_addr, 32'h2000);
        // fill, then continuous drain
        tick();
        check("acc_stream", out_stream, 0);
        tick();
        tick();
        tick();
        check("f2_occ", occupancy, 4);
        check("f2_addr", cache_addr, 32'h2040);
        out_ready = 1'b1;
        tick();
        check("drain_first_occ", occupancy, 3);
        check("drain_first_head", out_pc, 32'h2010);
        check("drain_first_addr", cache_addr, 32'h2040);
        exp_head = 32'h2010;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_head = exp_head + 32'h10;
            check("stream_head", out_pc, exp_head);
            check("stream_occ", occupancy, 3);
        end
        check("stream_addr", cache_addr, 32'h20A0);
        // redirect while full with a pending pop
        out_ready = 1'b0;
        tick();
        check("refull_occ", occupancy, 4);
        out_ready = 1'b1;
        load_pc = 1'b1;
        new_pc = 32'h3000;
        tick();
        load_pc = 1'b0;
        check("rf_valid", out_valid, 0);
        check("rf_occ", occupancy, 0);
        check("rf_addr", cache_addr, 32'h3000);
        tick();
        check("rf_pkt_pc", out_pc, 32'h3000);
        check("rf_pkt_stream", out_stream, 1);
        check("rf_pkt_occ", occupancy, 1);
        tick();
        out_ready = 1'b0;
        tick();
        check("pre_rst_occ", occupancy, 2);
        check("pre_rst_head", out_pc, 32'h3010);
        // asynchronous reset mid-stream
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_occ", occupancy, 0);
        check("arst_addr", cache_addr, 32'h0);
        check("arst_stream", out_stream, 0);
        #2 reset_n = 1'b1;
        tick();
        check("restart_pc", out_pc, 32'h0);
        check("restart_occ", occupancy, 1);
        check("restart_addr", cache_addr, 32'h10);
        check("restart_stream", out_stream, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
